// File: rtl/miner_pkg.sv
// Shared CSR map, word counts and FSM encoding for the miner job master.
package miner_pkg;
  localparam logic [4:0] ADDR_STATUS      = 5'd0;
  localparam logic [4:0] ADDR_CTRL        = 5'd1;
  localparam logic [4:0] ADDR_TARGET_BASE = 5'd2;
  localparam logic [4:0] ADDR_NONCE       = 5'd10;
  localparam logic [4:0] ADDR_MSG_BASE    = 5'd11;

  localparam int TARGET_WORDS = 8;
  localparam int MSG_WORDS    = 19;

  localparam int STAT_COMPLETE   = 0;
  localparam int STAT_FOUND      = 1;
  localparam int CTRL_NEW_TARGET = 0;
  localparam int CTRL_NEW_MSG    = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_TGT,
    S_WR_MSG,
    S_CTRL_CLR,
    S_CTRL_SET,
    S_POLL_WAIT,
    S_POLL_RD,
    S_RD_NONCE,
    S_RESULT
  } state_e;
endpackage

// File: rtl/avalon_master_port.sv
// Single-outstanding Avalon-MM command engine; o_done pulses on write
// acceptance or on read data return (o_rdata valid in that cycle).
module avalon_master_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [4:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid
);
  logic        r_wr;
  logic        r_rd;
  logic        r_pend;
  logic [4:0]  r_addr;
  logic [31:0] r_wdata;
  logic        w_acc;

  assign w_acc  = (r_wr | r_rd) & ~m_waitrequest;
  assign o_done = (r_wr & ~m_waitrequest) | (r_pend & m_readdatavalid);
  assign o_rdata = m_readdata;

  assign m_address    = r_addr;
  assign m_writedata  = r_wdata;
  assign m_write      = r_wr;
  assign m_read       = r_rd;
  assign m_chipselect = r_wr | r_rd;

  // A new command may be loaded in the same cycle the previous one completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_start) begin
      r_wr    <= i_write;
      r_rd    <= ~i_write;
      r_pend  <= 1'b0;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (w_acc) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_pend  <= r_rd;
    end else if (r_pend && m_readdatavalid) begin
      r_pend  <= 1'b0;
    end
  end
endmodule

// File: rtl/miner_job_master.sv
// Programs a miner over Avalon-MM, polls it and returns the result.
// Optional poll timeout enabled by defining MINER_TIMEOUT_EN.
import miner_pkg::*;

module miner_job_master #(
  parameter int POLL_GAP       = 16,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_target,
  input  logic [607:0] job_msg,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic [31:0]  res_nonce,
  output logic         res_timeout,
  output logic         busy,
  output logic [4:0]   m_address,
  output logic         m_chipselect,
  output logic         m_write,
  output logic         m_read,
  output logic [31:0]  m_writedata,
  input  logic         m_waitrequest,
  input  logic [31:0]  m_readdata,
  input  logic         m_readdatavalid
);
  state_e       r_state;
  state_e       w_state_n;
  logic [4:0]   r_idx;
  logic [4:0]   w_idx_n;
  logic [31:0]  r_gap;
  logic [255:0] r_target;
  logic [607:0] r_msg;
  logic         r_found;
  logic [31:0]  r_nonce;
  logic         r_res_to;
  logic         w_issue;
  logic         w_wr;
  logic [4:0]   w_addr;
  logic [31:0]  w_wdata;
  logic         w_done;
  logic [31:0]  w_rdata;
  logic         w_to;
  logic         w_accept;

  assign w_accept    = (r_state == S_IDLE) && job_valid;
  assign job_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign res_valid   = (r_state == S_RESULT);
  assign res_found   = r_found;
  assign res_nonce   = r_nonce;
  assign res_timeout = r_res_to;

`ifdef MINER_TIMEOUT_EN
  logic [31:0] r_tcnt;
  assign w_to = (r_tcnt >= 32'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tcnt <= '0;
    else if (w_accept)
      r_tcnt <= '0;
    else if ((r_state == S_POLL_WAIT || r_state == S_POLL_RD) && !w_to)
      r_tcnt <= r_tcnt + 32'd1;
  end
`else
  localparam int w_unused_to = TIMEOUT_CYCLES;
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_issue   = 1'b0;
    unique case (r_state)
      S_IDLE: if (job_valid) begin
        w_state_n = S_WR_TGT;
        w_idx_n   = '0;
        w_issue   = 1'b1;
      end
      S_WR_TGT: if (w_done) begin
        w_issue = 1'b1;
        if (r_idx == 5'(TARGET_WORDS - 1)) begin
          w_state_n = S_WR_MSG;
          w_idx_n   = '0;
        end else begin
          w_idx_n = r_idx + 5'd1;
        end
      end
      S_WR_MSG: if (w_done) begin
        w_issue = 1'b1;
        if (r_idx == 5'(MSG_WORDS - 1))
          w_state_n = S_CTRL_CLR;
        else
          w_idx_n = r_idx + 5'd1;
      end
      S_CTRL_CLR: if (w_done) begin
        w_state_n = S_CTRL_SET;
        w_issue   = 1'b1;
      end
      S_CTRL_SET: if (w_done) w_state_n = S_POLL_WAIT;
      S_POLL_WAIT:
        if (w_to) begin
          w_state_n = S_RESULT;
        end else if (r_gap == 32'(POLL_GAP - 1)) begin
          w_state_n = S_POLL_RD;
          w_issue   = 1'b1;
        end
      S_POLL_RD: if (w_done) begin
        if (w_to || (w_rdata[STAT_COMPLETE] && !w_rdata[STAT_FOUND]))
          w_state_n = S_RESULT;
        else if (!w_rdata[STAT_COMPLETE])
          w_state_n = S_POLL_WAIT;
        else begin
          w_state_n = S_RD_NONCE;
          w_issue   = 1'b1;
        end
      end
      S_RD_NONCE: if (w_done) w_state_n = S_RESULT;
      S_RESULT: if (res_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Command for the state being entered; word 0 comes straight off the job bus.
  always_comb begin
    w_wr    = 1'b1;
    w_addr  = '0;
    w_wdata = '0;
    case (w_state_n)
      S_WR_TGT: begin
        w_addr  = ADDR_TARGET_BASE + w_idx_n;
        w_wdata = (r_state == S_IDLE) ? job_target[31:0]
                                      : r_target[{w_idx_n[2:0], 5'b0} +: 32];
      end
      S_WR_MSG: begin
        w_addr  = ADDR_MSG_BASE + w_idx_n;
        w_wdata = r_msg[{w_idx_n, 5'b0} +: 32];
      end
      S_CTRL_CLR: w_addr = ADDR_CTRL;
      S_CTRL_SET: begin
        w_addr  = ADDR_CTRL;
        w_wdata = (32'd1 << CTRL_NEW_TARGET) | (32'd1 << CTRL_NEW_MSG);
      end
      S_POLL_RD: begin
        w_wr   = 1'b0;
        w_addr = ADDR_STATUS;
      end
      S_RD_NONCE: begin
        w_wr   = 1'b0;
        w_addr = ADDR_NONCE;
      end
      default: w_wr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_gap    <= '0;
      r_target <= '0;
      r_msg    <= '0;
      r_found  <= 1'b0;
      r_nonce  <= '0;
      r_res_to <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_gap   <= (r_state == S_POLL_WAIT && w_state_n == S_POLL_WAIT)
                 ? r_gap + 32'd1 : '0;
      if (w_accept) begin
        r_target <= job_target;
        r_msg    <= job_msg;
        r_found  <= 1'b0;
        r_nonce  <= '0;
        r_res_to <= 1'b0;
      end else if (w_state_n == S_RESULT && r_state != S_RESULT) begin
        r_found  <= (r_state == S_RD_NONCE);
        r_nonce  <= (r_state == S_RD_NONCE) ? w_rdata : 32'd0;
        r_res_to <= (r_state != S_RD_NONCE) && w_to;
      end
    end
  end

  avalon_master_port u_port (
    .clk             (clk),
    .rst             (rst),
    .i_start         (w_issue),
    .i_write         (w_wr),
    .i_addr          (w_addr),
    .i_wdata         (w_wdata),
    .o_done          (w_done),
    .o_rdata         (w_rdata),
    .m_address       (m_address),
    .m_chipselect    (m_chipselect),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );
endmodule

// File: tb/tb_miner_job_master.sv
// Bench for miner_job_master: slave model, expected-write scoreboard,
// result checks, reset and (with MINER_TIMEOUT_EN) timeout scenarios.
module tb_miner_job_master;
  localparam int GAP = 16;
  localparam int TO  = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [255:0] job_target = '0;
  logic [607:0] job_msg = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic         res_timeout;
  logic         busy;
  logic [4:0]   m_address;
  logic         m_chipselect;
  logic         m_write;
  logic         m_read;
  logic [31:0]  m_writedata;
  logic         m_waitrequest = 1'b0;
  logic [31:0]  m_readdata = '0;
  logic         m_readdatavalid = 1'b0;

  miner_job_master #(.POLL_GAP(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_target(job_target), .job_msg(job_msg),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_nonce(res_nonce),
    .res_timeout(res_timeout), .busy(busy),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_read(m_read),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] stat_q[$];
  logic [31:0] nonce_resp = 32'h0;
  bit          stall_en = 1'b0;
  bit          stray_en = 1'b0;
  int          wr_cnt = 0;
  int          n_stat = 0;
  int          n_nonce = 0;
  int          last_stat = -1;
  int          set_cyc = 0;
  logic [4:0]  first_a = '0;
  logic [31:0] first_d = '0;
  logic [31:0] last_d = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected CSR write stream for one job, straight from the CSR map.
  task automatic push_job(input logic [255:0] t, input logic [607:0] m);
    for (int i = 0; i < 8; i++) exp_q.push_back('{5'(2 + i), t[32*i +: 32]});
    for (int j = 0; j < 19; j++) exp_q.push_back('{5'(11 + j), m[32*j +: 32]});
    exp_q.push_back('{5'd1, 32'd0});
    exp_q.push_back('{5'd1, 32'd3});
  endtask

  // Slave model
  initial begin
    int   scnt;
    bit   pend;
    logic [31:0] pdata;
    scnt = 0;
    pend = 1'b0;
    pdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 1'b0;
        scnt = 0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata = 32'h0BAD_0BAD;
        if (pend) begin
          m_readdatavalid = 1'b1;
          m_readdata = pdata;
          pend = 1'b0;
        end else if (stray_en && !m_read && (cyc % 5 == 0)) begin
          m_readdatavalid = 1'b1;
          m_readdata = 32'h3;
        end
        m_waitrequest = 1'b0;
        if (m_write && stall_en) begin
          if (scnt < 3) begin
            m_waitrequest = 1'b1;
            scnt++;
          end else begin
            scnt = 0;
          end
        end
        if (m_read) begin
          pend = 1'b1;
          pdata = 32'h0;
          if (m_address == 5'd0) begin
            if (stat_q.size() > 0) pdata = stat_q.pop_front();
            n_stat++;
            if (last_stat >= 0)
              chk("poll_gap", 64'((cyc - last_stat - 1) >= GAP), 1);
            last_stat = cyc;
          end else if (m_address == 5'd10) begin
            pdata = nonce_resp;
            n_nonce++;
          end
        end
      end
    end
  end

  // Per-cycle compare process
  bit          prev_stall = 1'b0;
  logic [38:0] prev_bus = '0;
  wr_t         e;
  always @(negedge clk) begin
    if (!rst) begin
      chk("chipselect", m_chipselect, m_write | m_read);
      chk("busy_vs_ready", busy, !job_ready);
      chk("valid_ready_excl", res_valid & job_ready, 0);
      chk("one_strobe", m_write & m_read, 0);
      if (prev_stall)
        chk("stall_hold", {m_address, m_writedata, m_write, m_read}, prev_bus);
      if (m_write && !m_waitrequest) begin
        wr_cnt++;
        if (wr_cnt == 1) begin
          first_a = m_address;
          first_d = m_writedata;
        end
        last_d = m_writedata;
        if (m_address == 5'd1 && m_writedata == 32'd3) set_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", m_address, e.a);
          chk("wr_data", m_writedata, e.d);
        end
      end
      prev_stall = (m_write | m_read) && m_waitrequest;
      prev_bus = {m_address, m_writedata, m_write, m_read};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_job(input logic [255:0] t, input logic [607:0] m);
    push_job(t, m);
    wr_cnt = 0;
    n_stat = 0;
    n_nonce = 0;
    last_stat = -1;
    @(posedge clk);
    #1;
    job_target = t;
    job_msg = m;
    job_valid = 1'b1;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic run_job(input logic [255:0] t, input logic [607:0] m,
                         input bit x_found, input logic [31:0] x_nonce,
                         input bit x_to, input int x_nstat, input int hold);
    bit got;
    int res_cyc;
    got = 1'b0;
    res_cyc = 0;
    start_job(t, m);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        res_cyc = cyc;
        break;
      end
    end
    chk("res_valid_seen", got, 1);
    if (got) begin
      chk("res_found", res_found, x_found);
      chk("res_nonce", res_nonce, x_nonce);
      chk("res_timeout", res_timeout, x_to);
      if (x_to)
        chk("timeout_latency",
            64'((res_cyc - set_cyc) >= TO && (res_cyc - set_cyc) <= TO + 30), 1);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", res_valid, 1);
        chk("hold_found", res_found, x_found);
        chk("hold_nonce", res_nonce, x_nonce);
        chk("hold_job_ready", job_ready, 0);
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk("back_idle_ready", job_ready, 1);
      chk("back_idle_valid", res_valid, 0);
    end
    chk("wr_count", wr_cnt, 29);
    chk("exp_left", exp_q.size(), 0);
    chk("nonce_reads", n_nonce, x_found ? 1 : 0);
    if (x_nstat >= 0) chk("status_reads", n_stat, x_nstat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] t;
    logic [607:0] m;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bus", {m_write, m_read, m_chipselect, m_address, m_writedata}, 0);
    chk("rst_res", {res_valid, res_found, res_nonce, res_timeout}, 0);
    rst = 1'b0;

    // Job 1: ordered words, two busy polls then found, stray readdatavalid
    for (int i = 0; i < 8; i++) t[32*i +: 32] = 32'h1000_0000 + 32'(i);
    for (int j = 0; j < 19; j++) m[32*j +: 32] = 32'h2000_0000 + 32'(j);
    stat_q = '{32'h0, 32'h0, 32'h3};
    nonce_resp = 32'hDEAD_BEEF;
    stray_en = 1'b1;
    run_job(t, m, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 10);
    stray_en = 1'b0;
    chk("pin_first_addr", first_a, 5'd2);
    chk("pin_first_data", first_d, 32'h1000_0000);
    chk("pin_last_ctrl", last_d, 32'h3);

    // Job 2: 3-cycle stall per write, complete without found
    stall_en = 1'b1;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = 32'hA000_0000 ^ (32'h0101_0101 * 32'(i));
    for (int j = 0; j < 19; j++) m[32*j +: 32] = 32'h3000_0000 + 32'h11 * 32'(j);
    stat_q = '{32'h1};
    nonce_resp = 32'h5555_5555;
    run_job(t, m, 1'b0, 32'h0, 1'b0, 1, 0);
    stall_en = 1'b0;

    // Reset while writing the message words
    for (int i = 0; i < 8; i++) t[32*i +: 32] = 32'hC000_0000 + 32'(i);
    for (int j = 0; j < 19; j++) m[32*j +: 32] = 32'hD000_0000 + 32'(j);
    start_job(t, m);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wr_cnt >= 12) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached_wr_msg", seen, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_strobes", {m_write, m_read, m_chipselect}, 0);
    chk("arst_job_ready", job_ready, 1);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    stat_q.delete();

    // Job 4: fresh job after reset, found on first poll
    for (int i = 0; i < 8; i++) t[32*i +: 32] = 32'h7700_0000 | 32'(i << 4);
    for (int j = 0; j < 19; j++) m[32*j +: 32] = ~(32'h4000_0000 + 32'(j));
    stat_q = '{32'h3};
    nonce_resp = 32'h1234_5678;
    run_job(t, m, 1'b1, 32'h1234_5678, 1'b0, 1, 2);

`ifdef MINER_TIMEOUT_EN
    // Status never completes: timeout after TO poll cycles
    stat_q.delete();
    for (int i = 0; i < 8; i++) t[32*i +: 32] = 32'h0F0F_0000 + 32'(i);
    for (int j = 0; j < 19; j++) m[32*j +: 32] = 32'h00E0_0000 + 32'(j);
    run_job(t, m, 1'b0, 32'h0, 1'b1, -1, 3);
`endif

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
